// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory interface: beat width, line geometry
// and the responder's state encoding.
package mem_if_pkg;

  localparam int unsigned MEM_DATA_BITS  = 128;
  localparam int unsigned BEATS_PER_LINE = 4;
  localparam int unsigned MASK_BITS      = MEM_DATA_BITS / 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst
  } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port backing store: byte-masked synchronous write, registered read.
// Each byte lane is its own array so block-RAM byte enables map directly.
module mem_responder_array #(
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_BITS-1:0]    wdata,
  input  logic [DATA_BITS/8-1:0]  be,
  output logic [DATA_BITS-1:0]    rdata
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned Lanes = DATA_BITS / 8;

  for (genvar g = 0; g < Lanes; g++) begin : g_lane
    logic [7:0] lane [Depth];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we && be[g]) begin
        lane[addr] <= wdata[8*g +: 8];
      end
      // Read register holds its value between bursts.
      if (reset) begin
        q <= '0;
      end else if (re) begin
        q <= lane[addr];
      end
    end

    assign rdata[8*g +: 8] = q;
  end

endmodule

// File: rtl/mem_responder.sv
// DRAM stand-in: accepts masked single-beat writes and answers each read with a
// fixed-latency burst of consecutive beats.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned DATA_BITS  = MEM_DATA_BITS,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned BEATS      = BEATS_PER_LINE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  input  logic [ADDR_BITS-1:0]    mem_req_addr,
  input  logic                    mem_req_rw,
  input  logic                    mem_req_data_valid,
  output logic                    mem_req_data_ready,
  input  logic [DATA_BITS-1:0]    mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0]  mem_req_data_mask,
  output logic                    mem_resp_valid,
  output logic [DATA_BITS-1:0]    mem_resp_data
);

  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e                state;
  logic [7:0]            lat_cnt;
  logic [BeatW-1:0]      beat;
  logic [DEPTH_LOG2-1:0] base;

  logic                  idle;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  arr_re;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic                  unused_addr;

  assign idle               = (state == StIdle);
  assign mem_req_ready      = idle;
  assign mem_req_data_ready = idle;
  assign rd_accept          = mem_req_valid & idle & ~mem_req_rw;
  assign wr_accept          = mem_req_valid & mem_req_data_valid & mem_req_rw & idle & ~reset;

  // In BURST the array is addressed one cycle ahead of the beat it returns.
  assign arr_re   = (state == StBurst);
  assign arr_addr = arr_re ? base + DEPTH_LOG2'(beat) : mem_req_addr[DEPTH_LOG2-1:0];

  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      lat_cnt        <= '0;
      beat           <= '0;
      base           <= '0;
      mem_resp_valid <= 1'b0;
    end else begin
      mem_resp_valid <= (state == StBurst);
      unique case (state)
        StIdle: begin
          if (rd_accept) begin
            base    <= mem_req_addr[DEPTH_LOG2-1:0];
            lat_cnt <= 8'(LATENCY - 1);
            state   <= StWait;
          end
        end
        StWait: begin
          if (lat_cnt == '0) begin
            beat  <= '0;
            state <= StBurst;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        StBurst: begin
          if (beat == BeatW'(BEATS - 1)) begin
            beat  <= '0;
            state <= StIdle;
          end else begin
            beat <= beat + BeatW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  mem_responder_array #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_accept),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (mem_req_data_bits),
    .be    (mem_req_data_mask),
    .rdata (mem_resp_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a flat array model.
module tb_mem_responder;

  localparam int unsigned LAT   = 4;
  localparam int unsigned NBEAT = 4;
  localparam int unsigned DEPTH = 4096;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  logic [127:0] mdl [DEPTH];
  int           n_total = 0;
  int           n_pass  = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS  (28),
    .DATA_BITS  (128),
    .DEPTH_LOG2 (12),
    .LATENCY    (LAT),
    .BEATS      (NBEAT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rw         (mem_req_rw),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] mask);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = mask[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
  endtask

  // One complete write: must be accepted in the cycle it is offered.
  task automatic wr(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
    check("wr_ready", mem_req_ready, 1'b1);
    check("wr_data_ready", mem_req_data_ready, 1'b1);
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_data_valid = 1'b1;
    mem_req_addr = addr; mem_req_data_bits = data; mem_req_data_mask = mask;
    step();
    mdl[addr[11:0]] = merge(mdl[addr[11:0]], data, mask);
    idle_inputs();
  endtask

  // Read with a cycle-by-cycle response check; optionally offers a write to the
  // same entry while the read is outstanding, which must be ignored.
  task automatic rd(input logic [27:0] addr, input bit offer_wr);
    logic [11:0] idx;
    bit          exp_v;
    check("rd_ready", mem_req_ready, 1'b1);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = addr;
    step();
    idle_inputs();
    for (int k = 1; k <= int'(LAT + NBEAT + 1); k++) begin
      mem_req_addr = 28'($urandom);
      if (offer_wr && k <= 2) begin
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_data_valid = 1'b1;
        mem_req_addr = addr; mem_req_data_bits = rnd128(); mem_req_data_mask = 16'hFFFF;
      end
      step();
      idle_inputs();
      exp_v = (k >= int'(LAT + 1)) && (k <= int'(LAT + NBEAT));
      check("resp_valid", mem_resp_valid, exp_v);
      if (exp_v) begin
        idx = addr[11:0] + 12'(k - int'(LAT) - 1);
        check("resp_data", mem_resp_data, mdl[idx]);
      end
      if (k <= int'(LAT)) begin
        check("busy_req_ready", mem_req_ready, 1'b0);
        check("busy_data_ready", mem_req_data_ready, 1'b0);
      end
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    mem_req_addr = '0; mem_req_data_bits = '0; mem_req_data_mask = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_resp_valid", mem_resp_valid, 1'b0);
    check("rst_resp_data", mem_resp_data, '0);
    check("rst_req_ready", mem_req_ready, 1'b1);
    check("rst_data_ready", mem_req_data_ready, 1'b1);

    // Fill every entry so any burst has known contents (also a long back-to-back run).
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_data_valid = 1'b1;
      mem_req_addr = 28'(i); mem_req_data_bits = rnd128(); mem_req_data_mask = 16'hFFFF;
      step();
      mdl[i] = mem_req_data_bits;
    end
    idle_inputs();
    step();

    // Full write then read.
    wr(28'h10, 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D, 16'hFFFF);
    rd(28'h10, 1'b0);

    // Byte-mask merge.
    wr(28'h20, {128{1'b1}}, 16'hFFFF);
    wr(28'h20, '0, 16'h000F);
    check("mask_model", mdl[12'h20], {{96{1'b1}}, 32'h0});
    rd(28'h20, 1'b0);

    // Incomplete writes are not accepted; readies stay high in IDLE.
    for (int i = 0; i < 3; i++) begin
      mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_data_valid = 1'b0;
      mem_req_addr = 28'h40; mem_req_data_bits = rnd128(); mem_req_data_mask = 16'hFFFF;
      check("gate_req_ready", mem_req_ready, 1'b1);
      check("gate_data_ready", mem_req_data_ready, 1'b1);
      step();
    end
    mem_req_valid = 1'b0; mem_req_data_valid = 1'b1;
    step();
    mem_req_valid = 1'b1;
    check("gate_req_ready", mem_req_ready, 1'b1);
    step();
    mdl[12'h40] = mem_req_data_bits;
    idle_inputs();
    rd(28'h40, 1'b0);
    mem_req_data_bits = rnd128();
    mem_req_valid = 1'b0; mem_req_rw = 1'b1; mem_req_data_valid = 1'b1;
    step();
    idle_inputs();
    rd(28'h40, 1'b0);

    // Writes offered during WAIT/BURST are dropped.
    rd(28'h50, 1'b1);
    rd(28'h50, 1'b0);

    // Wrap-around and upper-bit aliasing.
    rd(28'hFFE, 1'b0);
    rd(28'h123_4FFF, 1'b0);

    // Reset after beat 1 aborts the burst.
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h30;
    step();
    idle_inputs();
    for (int k = 1; k <= int'(LAT + 2); k++) begin
      step();
      check("prerst_valid", mem_resp_valid, (k >= int'(LAT + 1)) ? 1'b1 : 1'b0);
    end
    check("prerst_beat1", mem_resp_data, mdl[12'h31]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", mem_resp_valid, 1'b0);
    check("midrst_ready", mem_req_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("postrst_valid", mem_resp_valid, 1'b0);
    end
    rd(28'h30, 1'b0);

    // Eight consecutive writes, then a read on the first cycle ready returns.
    for (int i = 0; i < 8; i++) wr(28'h200 + 28'(i), rnd128(), 16'($urandom));
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h200;
    step();
    idle_inputs();
    n = 0;
    while (!mem_req_ready && n < 20) begin
      step();
      n++;
    end
    check("b2b_ready_wait", (n < 20) ? 1'b1 : 1'b0, 1'b1);
    rd(28'h204, 1'b0);

    // Randomized mix of writes and reads.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 6) wr(28'($urandom), rnd128(), 16'($urandom));
      else rd(28'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
